// File: rtl/alu_opsel_pkg.sv
// Shared select widths, select codes and select enums for the ALU operand stage.
package alu_opsel_pkg;

    localparam int ALUA_SEL_W = 2;
    localparam int ALUB_SEL_W = 2;

    // A operand source; codes 2 and 3 both give zero
    typedef enum logic [ALUA_SEL_W-1:0] {
        ALUA_SEL_RD1      = 2'd0,
        ALUA_SEL_PC       = 2'd1,
        ALUA_SEL_ZERO     = 2'd2,
        ALUA_SEL_ZERO_ALT = 2'd3
    } alua_sel_e;

    // B operand source
    typedef enum logic [ALUB_SEL_W-1:0] {
        ALUB_SEL_RD2  = 2'd0,
        ALUB_SEL_SEXT = 2'd1,
        ALUB_SEL_FOUR = 2'd2,
        ALUB_SEL_ZERO = 2'd3
    } alub_sel_e;

endpackage

// File: rtl/fwd_resolve.sv
// Combinational forwarding resolver for one source register.
// The lowest-index (youngest) matching forwarding source wins; x0 never forwards.
module fwd_resolve #(
    parameter int XLEN    = 64,
    parameter int NUM_FWD = 2,
    parameter int RADDR_W = 5
) (
    input  logic [RADDR_W-1:0]         rs,
    input  logic [XLEN-1:0]            rf_data,
    input  logic [NUM_FWD-1:0]         fwd_valid,
    input  logic [NUM_FWD-1:0]         fwd_pending,
    input  logic [NUM_FWD*RADDR_W-1:0] fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0]    fwd_data,
    output logic [XLEN-1:0]            value,
    output logic                       hazard
);

    // Scan oldest to youngest so the youngest match overwrites older ones
    always_comb begin
        value  = rf_data;
        hazard = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_rd[i*RADDR_W +: RADDR_W] == rs)
                && (rs != {RADDR_W{1'b0}})) begin
                value  = fwd_data[i*XLEN +: XLEN];
                hazard = fwd_pending[i];
            end else begin
                value  = value;
                hazard = hazard;
            end
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered ALU operand-select stage between decode and execute.
// Forwards rs1/rs2 from NUM_FWD later stages, stalls on pending producers,
// and holds the selected operands in a one-entry valid/ready register.
// Optional macro ALU_OPSEL_WORD_EN: sign-extend A and B from bit 31 on word_op.
module alu_operand_stage
    import alu_opsel_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int NUM_FWD = 2,
    parameter int RADDR_W = 5
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [RADDR_W-1:0]         rs1,
    input  logic [RADDR_W-1:0]         rs2,
    input  logic [XLEN-1:0]            rd1,
    input  logic [XLEN-1:0]            rd2,
    input  logic [XLEN-1:0]            pc,
    input  logic [XLEN-1:0]            sext,
    input  logic [ALUA_SEL_W-1:0]      alua_sel,
    input  logic [ALUB_SEL_W-1:0]      alub_sel,
    input  logic                       word_op,
    input  logic [NUM_FWD-1:0]         fwd_valid,
    input  logic [NUM_FWD-1:0]         fwd_pending,
    input  logic [NUM_FWD*RADDR_W-1:0] fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0]    fwd_data,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            A,
    output logic [XLEN-1:0]            B,
    output logic [XLEN-1:0]            store_data
);

    logic [XLEN-1:0] rs1_val_s;
    logic [XLEN-1:0] rs2_val_s;
    logic            rs1_haz_s;
    logic            rs2_haz_s;
    logic            hazard_s;
    logic            capture_s;
    logic [XLEN-1:0] a_sel_s;
    logic [XLEN-1:0] b_sel_s;

    logic            out_valid_d, out_valid_q;
    logic [XLEN-1:0] a_d, a_q;
    logic [XLEN-1:0] b_d, b_q;
    logic [XLEN-1:0] sd_d, sd_q;

    fwd_resolve #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .RADDR_W(RADDR_W)) u_fwd_rs1 (
        .rs          (rs1),
        .rf_data     (rd1),
        .fwd_valid   (fwd_valid),
        .fwd_pending (fwd_pending),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data),
        .value       (rs1_val_s),
        .hazard      (rs1_haz_s)
    );

    fwd_resolve #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .RADDR_W(RADDR_W)) u_fwd_rs2 (
        .rs          (rs2),
        .rf_data     (rd2),
        .fwd_valid   (fwd_valid),
        .fwd_pending (fwd_pending),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data),
        .value       (rs2_val_s),
        .hazard      (rs2_haz_s)
    );

    // rs1 stalls only when A uses it; rs2 always stalls since store_data needs it
    always_comb begin
        hazard_s  = (rs1_haz_s && (alua_sel_e'(alua_sel) == ALUA_SEL_RD1)) || rs2_haz_s;
        in_ready  = !hazard_s && (!out_valid_q || out_ready);
        capture_s = in_valid && in_ready && !flush;
    end

    // Operand muxes, with optional 32-bit sign extension for word instructions
    always_comb begin
        case (alua_sel_e'(alua_sel))
            ALUA_SEL_RD1: a_sel_s = rs1_val_s;
            ALUA_SEL_PC:  a_sel_s = pc;
            default:      a_sel_s = {XLEN{1'b0}};
        endcase
        case (alub_sel_e'(alub_sel))
            ALUB_SEL_RD2:  b_sel_s = rs2_val_s;
            ALUB_SEL_SEXT: b_sel_s = sext;
            ALUB_SEL_FOUR: b_sel_s = {{(XLEN-3){1'b0}}, 3'd4};
            default:       b_sel_s = {XLEN{1'b0}};
        endcase
`ifdef ALU_OPSEL_WORD_EN
        if (word_op) begin
            a_sel_s = {{(XLEN-32){a_sel_s[31]}}, a_sel_s[31:0]};
            b_sel_s = {{(XLEN-32){b_sel_s[31]}}, b_sel_s[31:0]};
        end else begin
            a_sel_s = a_sel_s;
            b_sel_s = b_sel_s;
        end
`endif
    end

`ifndef ALU_OPSEL_WORD_EN
    logic unused_word_op_s;
    assign unused_word_op_s = word_op;
`endif

    // Next-state: flush beats capture, capture beats consume, else hold
    always_comb begin
        out_valid_d = out_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        sd_d        = sd_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture_s) begin
            out_valid_d = 1'b1;
            a_d         = a_sel_s;
            b_d         = b_sel_s;
            sd_d        = rs2_val_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline register with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            a_q         <= {XLEN{1'b0}};
            b_q         <= {XLEN{1'b0}};
            sd_q        <= {XLEN{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sd_q        <= sd_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign A          = a_q;
    assign B          = b_q;
    assign store_data = sd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus random
// traffic, all compared against a first-match forwarding reference model.
module tb_alu_operand_stage;

    localparam int XLEN = 64;
    localparam int NF   = 2;
    localparam int RW   = 5;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [RW-1:0]   rs1, rs2;
    logic [XLEN-1:0] rd1, rd2, pc, sext;
    logic [1:0]      alua_sel, alub_sel;
    logic            word_op;
    logic [NF-1:0]   fwd_valid, fwd_pending;
    logic [NF*RW-1:0]   fwd_rd;
    logic [NF*XLEN-1:0] fwd_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] A, B, store_data;

    logic [RW-1:0]   frd [NF];
    logic [XLEN-1:0] fdat[NF];
    assign fwd_rd   = {frd[1], frd[0]};
    assign fwd_data = {fdat[1], fdat[0]};

    // Reference state
    logic            m_valid;
    logic [XLEN-1:0] m_a, m_b, m_sd;
    logic            last_hold;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_operand_stage #(.XLEN(XLEN), .NUM_FWD(NF), .RADDR_W(RW)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2), .pc(pc), .sext(sext),
        .alua_sel(alua_sel), .alub_sel(alub_sel), .word_op(word_op),
        .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .A(A), .B(B), .store_data(store_data)
    );

    task automatic check_eq(input string tag, input logic [XLEN-1:0] got,
                            input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // First matching forwarding source (youngest first) supplies the value
    function automatic void resolve(input logic [RW-1:0] rs, input logic [XLEN-1:0] rf,
                                    output logic [XLEN-1:0] val, output logic hz);
        val = rf;
        hz  = 1'b0;
        if (rs != 0) begin
            for (int i = 0; i < NF; i++) begin
                if (fwd_valid[i] && frd[i] == rs) begin
                    val = fdat[i];
                    hz  = fwd_pending[i];
                    break;
                end
            end
        end
    endfunction

    function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] x);
`ifdef ALU_OPSEL_WORD_EN
        if (word_op) return XLEN'($signed(x[31:0]));
`endif
        return x;
    endfunction

    // One cycle: inputs already set after a negedge; check in_ready, then outputs
    task automatic tick();
        logic [XLEN-1:0] v1, v2, ea, eb;
        logic h1, h2, hz, rdy, cap;
        #1;
        resolve(rs1, rd1, v1, h1);
        resolve(rs2, rd2, v2, h2);
        hz  = (h1 && alua_sel == 2'd0) || h2;
        rdy = !hz && (!m_valid || out_ready);
        check_eq("in_ready", {63'd0, in_ready}, {63'd0, rdy});
        cap = in_valid && rdy && !flush;
        ea = (alua_sel == 2'd0) ? v1 : (alua_sel == 2'd1) ? pc : 64'd0;
        eb = (alub_sel == 2'd0) ? v2 : (alub_sel == 2'd1) ? sext :
             (alub_sel == 2'd2) ? 64'd4 : 64'd0;
        last_hold = in_valid && hz && !flush;
        @(posedge clk);
        if (flush) m_valid = 1'b0;
        else if (cap) begin
            m_valid = 1'b1;
            m_a = word_ext(ea);
            m_b = word_ext(eb);
            m_sd = v2;
        end else if (out_ready) m_valid = 1'b0;
        #1;
        check_eq("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
        if (m_valid) begin
            check_eq("A", A, m_a);
            check_eq("B", B, m_b);
            check_eq("store_data", store_data, m_sd);
        end
        @(negedge clk);
    endtask

    task automatic clear_fwd();
        fwd_valid = 2'b00; fwd_pending = 2'b00;
        for (int i = 0; i < NF; i++) begin frd[i] = 5'd0; fdat[i] = 64'd0; end
    endtask

    task automatic rand_instr();
        in_valid = ($urandom_range(0, 3) != 0);
        rs1 = 5'($urandom_range(0, 3));
        rs2 = 5'($urandom_range(0, 3));
        rd1 = {$urandom, $urandom};
        rd2 = {$urandom, $urandom};
        pc = {$urandom, $urandom};
        sext = {$urandom, $urandom};
        alua_sel = 2'($urandom_range(0, 3));
        alub_sel = 2'($urandom_range(0, 3));
        word_op = 1'($urandom_range(0, 1));
    endtask

    task automatic rand_env();
        fwd_valid = 2'($urandom_range(0, 3));
        fwd_pending = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
        for (int i = 0; i < NF; i++) begin
            frd[i] = 5'($urandom_range(0, 3));
            fdat[i] = {$urandom, $urandom};
        end
        flush = ($urandom_range(0, 9) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        logic [XLEN-1:0] held_a;
        reset_n = 1'b0; in_valid = 1'b0; rs1 = 5'd0; rs2 = 5'd0;
        rd1 = 64'd0; rd2 = 64'd0; pc = 64'd0; sext = 64'd0;
        alua_sel = 2'd0; alub_sel = 2'd0; word_op = 1'b0;
        flush = 1'b0; out_ready = 1'b1; clear_fwd();
        m_valid = 1'b0; m_a = 64'd0; m_b = 64'd0; m_sd = 64'd0; last_hold = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_A", A, 64'd0);
        check_eq("rst_B", B, 64'd0);
        check_eq("rst_store_data", store_data, 64'd0);
        reset_n = 1'b1;

        // First instruction
        in_valid = 1'b1; rs1 = 5'd1; rs2 = 5'd2; rd1 = 64'd5; rd2 = 64'd7;
        tick();
        check_eq("first_A", A, 64'd5);
        check_eq("first_B", B, 64'd7);

        // Forward priority: youngest source wins
        rs1 = 5'd3; rs2 = 5'd0; rd1 = 64'h1234;
        fwd_valid = 2'b11; frd[0] = 5'd3; frd[1] = 5'd3;
        fdat[0] = 64'hAA; fdat[1] = 64'hBB;
        tick();
        check_eq("fwd_prio_A", A, 64'hAA);
        rs1 = 5'd0; frd[0] = 5'd0; frd[1] = 5'd0;
        tick();
        check_eq("fwd_x0_A", A, 64'h1234);

        // Load-use stall on rs2
        clear_fwd();
        rs1 = 5'd1; rs2 = 5'd6; rd2 = 64'h99;
        fwd_valid = 2'b01; frd[0] = 5'd6; fwd_pending = 2'b01;
        tick();
        check_eq("stall_ready_1", {63'd0, in_ready}, 64'd0);
        tick();
        check_eq("stall_ready_2", {63'd0, in_ready}, 64'd0);
        fwd_pending = 2'b00; fdat[0] = 64'h42;
        tick();
        check_eq("stall_B", B, 64'h42);

        // Backpressure then same-cycle replace
        clear_fwd();
        rd1 = 64'h111; rd2 = 64'h222; rs2 = 5'd2;
        tick();
        held_a = A;
        out_ready = 1'b0; rd1 = 64'h333;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("bp_A_stable", A, held_a);
        end
        out_ready = 1'b1; rd1 = 64'h444;
        tick();
        check_eq("replace_A", A, 64'h444);

        // Flush with a valid incoming and a held instruction
        out_ready = 1'b0; rd1 = 64'h555;
        tick();
        flush = 1'b1; rd1 = 64'h666;
        tick();
        check_eq("flush_out_valid", {63'd0, out_valid}, 64'd0);
        flush = 1'b0; out_ready = 1'b1;

        // Word mode
        rs1 = 5'd1; alua_sel = 2'd0; word_op = 1'b1; rd1 = 64'h0000_0001_8000_0000;
        tick();
`ifdef ALU_OPSEL_WORD_EN
        check_eq("word_A", A, 64'hFFFF_FFFF_8000_0000);
`else
        check_eq("word_A", A, 64'h0000_0001_8000_0000);
`endif
        word_op = 1'b0;

        // Asynchronous reset mid-operation
        out_ready = 1'b0; rd1 = 64'h777;
        tick();
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_valid", {63'd0, out_valid}, 64'd0);
        check_eq("async_rst_A", A, 64'd0);
        m_valid = 1'b0; m_a = 64'd0; m_b = 64'd0; m_sd = 64'd0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Random traffic; decode holds the instruction while it is stalled
        last_hold = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if (!last_hold) rand_instr();
            rand_env();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Registered operand-select stage between decode and execute. Chooses ALU operands A and B from register-file data, PC, the sign-extended immediate or the constant 4. Resolves RAW hazards by forwarding from `NUM_FWD` later pipeline stages, and stalls when a matching producer has not yet produced its data. Results sit in a one-entry valid/ready pipeline register with flush, so decode and execute decouple by one cycle.

## Interface
Parameters:
- `XLEN`, 64, datapath width.
- `NUM_FWD`, 2, number of forwarding sources; index 0 is the youngest (EX), higher indices are older.
- `RADDR_W`, 5, register index width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  decode presents an instruction.
- `in_ready`  out  1  stage accepts this cycle.
- `rs1`, `rs2`  in  RADDR_W  source register indices.
- `rd1`, `rd2`  in  XLEN  register-file read data.
- `pc`  in  XLEN  instruction address.
- `sext`  in  XLEN  sign-extended immediate.
- `alua_sel`  in  2  A source select.
- `alub_sel`  in  2  B source select.
- `word_op`  in  1  RV64 W-type instruction.
- `fwd_valid`  in  NUM_FWD  source i holds a register write.
- `fwd_pending`  in  NUM_FWD  source i writes, but its data is not yet available (for example, a load in EX).
- `fwd_rd`  in  NUM_FWD×RADDR_W  destination index per source.
- `fwd_data`  in  NUM_FWD×XLEN  write data per source.
- `flush`  in  1  kill the held and the incoming instruction.
- `out_valid`  out  1  operands valid.
- `out_ready`  in  1  execute consumes.
- `A`, `B`  out  XLEN  ALU operands.
- `store_data`  out  XLEN  forwarded rs2 value, independent of `alub_sel`.

## Operation
- **Forwarding per operand (rs1, rs2):**
  - Scan sources 0..NUM_FWD-1.
  - The first index with `fwd_valid` and `fwd_rd == rs` and `rs != 0` wins.
  - If the winner has `fwd_pending`, raise a hazard.
  - Otherwise the operand value is that source's `fwd_data`.
  - With no winner, use `rd1`/`rd2`.
  - rs == 0 always yields the raw `rd1`/`rd2`. It never forwards and never raises a hazard.
- **A select:** 0 = fwd rs1, 1 = `pc`, 2/3 = 0.
- **B select:** 0 = fwd rs2, 1 = `sext`, 2 = constant 4, 3 = 0.
- **Hazard rule:** a hazard is counted only if the operand is actually used. An rs1 hazard counts only when `alua_sel`==0. An rs2 hazard counts when `alub_sel`==0 or always for store_data. Decode marks rs2=0 for instructions without rs2.
- **Handshake:** `in_ready = !hazard && (!out_valid || out_ready)`. Capture occurs when `in_valid && in_ready && !flush`.
- **Register update priority (highest first):**
  1. `flush`: out_valid←0.
  2. Capture: load A, B and store_data; out_valid←1.
  3. `out_ready`: out_valid←0.
  4. Otherwise hold.
- While a hazard is present with `in_valid`, decode must hold its inputs stable.

## Timing
- Latency is 1 cycle from accept to `out_valid`. A back-to-back throughput of 1 per cycle is required when `out_ready` stays 1.
- `in_ready` and the hazard logic are combinational from the inputs and `out_valid`. `A`, `B` and `store_data` are registered; there is no combinational path from the inputs to them.
- Reset values: out_valid=0, A=0, B=0, store_data=0. `reset_n` low mid-operation drops the held instruction immediately and asynchronously.
- Consume and accept in the same cycle: the new data replaces the old and out_valid stays 1.
- Flush together with `in_valid` and `in_ready`: nothing is captured and out_valid=0 next cycle.
- `out_ready` with `out_valid`=0 has no effect.
- Data outputs hold their values while out_valid=0. The bench must not check them in that state.

## Configuration
- `ALU_OPSEL_WORD_EN`:
  - **Defined:** when `word_op`=1, captured A and B are sign-extended from bit 31 (`{{32{x[31]}},x[31:0]}`). `store_data` is unaffected.
  - **Undefined:** `word_op` is ignored and operands pass at full XLEN.

## Structure
- **Shared package `alu_opsel_pkg`:**
  - Select widths.
  - Select codes: `ALUA_SEL_RD1`=0, `ALUA_SEL_PC`=1, `ALUB_SEL_RD2`=0, `ALUB_SEL_SEXT`=1, `ALUB_SEL_FOUR`=2.
  - Typedefs for the select enums.
- **Sub-module `fwd_resolve`:** combinational. Inputs are one register index, its regfile data and the forwarding arrays. Outputs are the resolved value and the hazard flag. It is instantiated twice, for rs1 and rs2.

## Test plan
- Reset: hold reset_n=0, then release → out_valid=0, A=B=0. The first valid instruction with rd1=5, rd2=7, sel 0/0 gives A=5, B=7 one cycle after accept.
- Forward priority: rs1=3, fwd_valid=2'b11, fwd_rd={3,3}, fwd_data[0]=0xAA, fwd_data[1]=0xBB → A=0xAA. Then with rs1=0 and fwd_rd={0,0}, A=rd1.
- Load-use stall: fwd_pending[0]=1 matching rs2, alub_sel=0 → in_ready=0 for 2 cycles. Clear pending with fwd_data[0]=0x42 → accept, B=0x42.
- Backpressure: out_ready=0 for 3 cycles → A and B stable, in_ready=0. Then out_ready=1 with a new input → same-cycle replace, out_valid stays 1.
- Flush: flush=1 with in_valid and out_valid=1 → out_valid=0 next cycle and nothing captured.
- Word mode (macro defined): rd1=0x0000_0001_8000_0000, word_op=1 → A=0xFFFF_FFFF_8000_0000. Without the macro → A unchanged.
